// File: rtl/bus_timer.sv
// Memory-mapped 16-bit interval timer with prescaler, terminal-count flag and irq.
// Define BUS_TIMER_WAIT_EN to insert one wait-stated cycle (RD_WAIT) into every read.
module bus_timer #(
    parameter int unsigned PRESCALE_W = 8,
    parameter bit          IRQ_LEVEL  = 1'b1
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [2:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       wait_req,
    output logic       irq
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CTRL_W = 3;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_WAIT  = 2'd1;
    localparam logic [1:0] S_RD_DRIVE = 2'd2;
    localparam logic [1:0] S_WR_DONE  = 2'd3;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_RLD_LO = 3'd2;
    localparam logic [2:0] A_RLD_HI = 3'd3;
    localparam logic [2:0] A_CNT_LO = 3'd4;
    localparam logic [2:0] A_CNT_HI = 3'd5;
    localparam logic [2:0] A_PRESC  = 3'd6;

    logic [1:0]            state_q,    state_d;
    logic [CTRL_W-1:0]     ctrl_q,     ctrl_d;
    logic                  tc_q,       tc_d;
    logic [CNT_W-1:0]      rld_q,      rld_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  expired_q,  expired_d;
    logic [7:0]            latch_q,    latch_d;
    logic [PRESCALE_W-1:0] presc_q,    presc_d;
    logic [PRESCALE_W-1:0] pcnt_q,     pcnt_d;
    logic [7:0]            data_out_q, data_out_d;
    logic                  data_oe_q,  data_oe_d;
    logic                  wait_req_q, wait_req_d;
    logic                  irq_q,      irq_d;

    logic             rd_start;
    logic             wr_commit;
    logic             en_rise;
    logic             tc_clr;
    logic             tick;
    logic             tc_set;
    logic             en_clr;
    logic [CNT_W-1:0] eff;
    logic [7:0]       rd_data_c;

    // Strobe decode: accesses start only from IDLE, read wins over a simultaneous write
    assign rd_start  = (state_q == S_IDLE) && !cs_n && !rd_n;
    assign wr_commit = (state_q == S_IDLE) && !cs_n && !wr_n && rd_n;
    assign en_rise   = wr_commit && (addr == A_CTRL) && data_in[0] && !ctrl_q[0];
    assign tc_clr    = wr_commit && (addr == A_STATUS) && data_in[0];
    assign tick      = ctrl_q[0] && (pcnt_q >= presc_q);

    // Bus FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rd_start) begin
`ifdef BUS_TIMER_WAIT_EN
                    state_d = S_RD_WAIT;
`else
                    state_d = S_RD_DRIVE;
`endif
                end else if (wr_commit) begin
                    state_d = S_WR_DONE;
                end
            end
            S_RD_WAIT:  state_d = S_RD_DRIVE;
            S_RD_DRIVE: if (cs_n || rd_n) state_d = S_IDLE;
            S_WR_DONE:  if (cs_n || wr_n) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Read data mux
    always_comb begin
        rd_data_c = 8'h00;
        case (addr)
            A_CTRL:   rd_data_c = {5'd0, ctrl_q};
            A_STATUS: rd_data_c = {7'd0, tc_q};
            A_RLD_LO: rd_data_c = rld_q[7:0];
            A_RLD_HI: rd_data_c = rld_q[15:8];
            A_CNT_LO: rd_data_c = cnt_q[7:0];
            A_CNT_HI: rd_data_c = latch_q;
            A_PRESC:  rd_data_c = 8'(presc_q);
            default:  rd_data_c = 8'h00;
        endcase
    end

    // Bus-side outputs and the CNT_HI snapshot, taken on the same edge as CNT_LO
    always_comb begin
        data_out_d = data_out_q;
        latch_d    = latch_q;
        if (rd_start) begin
            data_out_d = rd_data_c;
            if (addr == A_CNT_LO) latch_d = cnt_q[15:8];
        end
        data_oe_d = (state_d == S_RD_DRIVE);
`ifdef BUS_TIMER_WAIT_EN
        wait_req_d = (state_d == S_RD_WAIT);
`else
        wait_req_d = 1'b0;
`endif
    end

    // Prescaler and down-counter; eff is the value being stepped this tick
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        pcnt_d    = pcnt_q;
        tc_set    = 1'b0;
        en_clr    = 1'b0;
        eff       = cnt_q;
        if (en_rise) begin
            cnt_d     = rld_q;
            expired_d = 1'b0;
            pcnt_d    = {PRESCALE_W{1'b0}};
        end else if (ctrl_q[0]) begin
            pcnt_d = tick ? {PRESCALE_W{1'b0}} : pcnt_q + PRESCALE_W'(1);
            if (tick) begin
                if (expired_q && !ctrl_q[1]) begin
                    en_clr = 1'b1;
                end else begin
                    // A periodic reload tick also counts as the first step of the new period
                    eff = expired_q ? rld_q : cnt_q;
                    if (eff == 16'd1) begin
                        cnt_d     = 16'd0;
                        expired_d = 1'b1;
                        tc_set    = 1'b1;
                    end else begin
                        cnt_d     = eff - 16'd1;
                        expired_d = 1'b0;
                        // A zero load flags TC on its first tick, then runs a full 65536 span
                        if ((eff == 16'd0) && !expired_q) tc_set = 1'b1;
                    end
                end
            end
        end
    end

    // Register file writes
    always_comb begin
        ctrl_d  = ctrl_q;
        rld_d   = rld_q;
        presc_d = presc_q;
        if (en_clr) ctrl_d[0] = 1'b0;
        if (wr_commit) begin
            case (addr)
                A_CTRL:   ctrl_d      = data_in[2:0];
                A_RLD_LO: rld_d[7:0]  = data_in;
                A_RLD_HI: rld_d[15:8] = data_in;
                A_PRESC:  presc_d     = PRESCALE_W'(data_in);
                default:  ;
            endcase
        end
    end

    // Terminal-count flag (set beats clear) and interrupt
    always_comb begin
        tc_d = tc_q;
        if (tc_clr) tc_d = 1'b0;
        if (tc_set) tc_d = 1'b1;
        if (IRQ_LEVEL) irq_d = tc_d && ctrl_d[2];
        else           irq_d = tc_d && !tc_q && ctrl_d[2];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            tc_q       <= 1'b0;
            rld_q      <= '0;
            cnt_q      <= '0;
            expired_q  <= 1'b0;
            latch_q    <= '0;
            presc_q    <= '0;
            pcnt_q     <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            wait_req_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            tc_q       <= tc_d;
            rld_q      <= rld_d;
            cnt_q      <= cnt_d;
            expired_q  <= expired_d;
            latch_q    <= latch_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            wait_req_q <= wait_req_d;
            irq_q      <= irq_d;
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign wait_req = wait_req_q;
    assign irq      = irq_q;

endmodule
